pong_match_ctrl: RTL

//  Match sequencer for the pong game. Owns scores, serve timing, ball hold/re-centre and game-over.

---
 rtl/pong_pkg.sv | 21 ++
 rtl/pong_match_ctrl_if.sv | 25 ++
 rtl/pong_frame_timer.sv | 24 ++
 rtl/pong_match_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, sound cue codes, winner codes and score helper for the pong match controller.
package pong_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;
    localparam logic [1:0] SND_NONE    = 2'b00;
    localparam logic [1:0] SND_POINT   = 2'b01;
    localparam logic [1:0] SND_OVER    = 2'b10;
    localparam logic [1:0] SND_SERVE   = 2'b11;
    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P0   = 2'b01;
    localparam logic [1:0] WINNER_P1   = 2'b10;
    localparam int DEF_WIN_SCORE = 9;
    function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
        return (s < lim) ? s + 4'd1 : s;
    endfunction
endpackage

// File: rtl/pong_match_ctrl_if.sv
// pong_match_ctrl_if: game-event inputs and match outputs of the pong match controller.
//   master: drives frame_tick/start_btn/goal_left/goal_right, observes the match outputs
//   slave : the controller (consumes events, drives ball_hold/ball_center/serve_dir/scores/winner/snd_req/autopilot)
interface pong_match_ctrl_if;
    logic       frame_tick;
    logic       start_btn;
    logic       goal_left;
    logic       goal_right;
    logic       ball_hold;
    logic       ball_center;
    logic       serve_dir;
    logic [3:0] score0_bcd;
    logic [3:0] score1_bcd;
    logic [1:0] winner;
    logic [1:0] snd_req;
    logic       autopilot;
    modport master (
        output frame_tick, start_btn, goal_left, goal_right,
        input  ball_hold, ball_center, serve_dir, score0_bcd, score1_bcd, winner, snd_req, autopilot
    );
    modport slave (
        input  frame_tick, start_btn, goal_left, goal_right,
        output ball_hold, ball_center, serve_dir, score0_bcd, score1_bcd, winner, snd_req, autopilot
    );
endinterface

// File: rtl/pong_frame_timer.sv
// pong_frame_timer: counts frame ticks since the last clear; done flags the tick that reaches limit.
//   clk, reset : clock, async active-high reset
//   clr        : restart count from zero (wins over tick)
//   tick       : frame_tick enable
//   limit      : terminal tick number (>=1)
//   done       : combinational, high on the limit-th tick
module pong_frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic         done
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     cnt_q <= '0;
        else if (clr)  cnt_q <= '0;
        else if (tick) cnt_q <= cnt_q + 1'b1;
    end
    assign done = tick && (cnt_q == limit - 1'b1);
endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: pong match sequencer - scores, serve timing, ball hold/re-centre, game-over, sound cues.
//   clk, reset : 25 MHz pixel clock, async active-high reset
//   bus        : pong_match_ctrl_if.slave (frame/goal/start events in, registered match outputs)
//   Optional PONG_ATTRACT_MODE_EN: ball runs under autopilot as a demo in IDLE/OVER.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE          = DEF_WIN_SCORE,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int POINT_DELAY_FRAMES = 30,
    parameter int FRAME_CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    pong_match_ctrl_if.slave  bus
);
    localparam logic [3:0]             WIN       = 4'(WIN_SCORE);
    localparam logic [FRAME_CNT_W-1:0] SERVE_LIM = FRAME_CNT_W'(SERVE_DELAY_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] POINT_LIM = FRAME_CNT_W'(POINT_DELAY_FRAMES);
    state_e     state_q, state_d;
    logic [3:0] score0_q, score0_d, score1_q, score1_d;
    logic [1:0] winner_q, winner_d, snd_q, snd_d;
    logic       dir_q, dir_d, center_q, center_d, hold_q, hold_d, auto_q, auto_d, start_q;
    logic       start_edge, goal, done;
    assign start_edge = bus.start_btn & ~start_q;
    assign goal       = bus.frame_tick & (bus.goal_left | bus.goal_right);
    // A restart from SERVE stays in SERVE, so the timer must also clear on a start edge.
    pong_frame_timer #(.W(FRAME_CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (start_edge || state_d != state_q),
        .tick  (bus.frame_tick),
        .limit (state_q == ST_SERVE ? SERVE_LIM : POINT_LIM),
        .done  (done)
    );
    always_comb begin
        state_d  = state_q;
        score0_d = score0_q;
        score1_d = score1_q;
        dir_d    = dir_q;
        winner_d = winner_q;
        snd_d    = SND_NONE;
        center_d = 1'b0;
        if (start_edge) begin
            state_d  = ST_SERVE;
            score0_d = 4'd0;
            score1_d = 4'd0;
            winner_d = WINNER_NONE;
            center_d = 1'b1;
            dir_d    = 1'b0;
        end else begin
            case (state_q)
                ST_SERVE: if (done) begin
                    state_d = ST_PLAY;
                    snd_d   = SND_SERVE;
                end
                ST_PLAY: if (goal) begin
                    state_d = ST_POINT;
                    snd_d   = SND_POINT;
                    if (bus.goal_left && bus.goal_right) dir_d = ~dir_q;
                    else if (bus.goal_left) begin
                        score0_d = sat_inc(score0_q, WIN);
                        dir_d    = 1'b0;
                    end else begin
                        score1_d = sat_inc(score1_q, WIN);
                        dir_d    = 1'b1;
                    end
                end
                ST_POINT: if (done) begin
                    if (score0_q == WIN || score1_q == WIN) begin
                        state_d  = ST_OVER;
                        winner_d = (score0_q == WIN) ? WINNER_P0 : WINNER_P1;
                        snd_d    = SND_OVER;
                    end else begin
                        state_d  = ST_SERVE;
                        center_d = 1'b1;
                    end
                end
`ifdef PONG_ATTRACT_MODE_EN
                ST_IDLE, ST_OVER: center_d = goal;
`endif
                default: ;
            endcase
        end
`ifdef PONG_ATTRACT_MODE_EN
        auto_d = (state_d == ST_IDLE) || (state_d == ST_OVER);
        hold_d = (state_d != ST_PLAY) && !auto_d;
`else
        auto_d = 1'b0;
        hold_d = state_d != ST_PLAY;
`endif
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            score0_q <= 4'd0;
            score1_q <= 4'd0;
            winner_q <= WINNER_NONE;
            snd_q    <= SND_NONE;
            dir_q    <= 1'b0;
            center_q <= 1'b0;
            hold_q   <= 1'b1;
            auto_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            score0_q <= score0_d;
            score1_q <= score1_d;
            winner_q <= winner_d;
            snd_q    <= snd_d;
            dir_q    <= dir_d;
            center_q <= center_d;
            hold_q   <= hold_d;
            auto_q   <= auto_d;
            start_q  <= bus.start_btn;
        end
    end
    assign bus.ball_hold   = hold_q;
    assign bus.ball_center = center_q;
    assign bus.serve_dir   = dir_q;
    assign bus.score0_bcd  = score0_q;
    assign bus.score1_bcd  = score1_q;
    assign bus.winner      = winner_q;
    assign bus.snd_req     = snd_q;
    assign bus.autopilot   = auto_q;
endmodule
